// File: rtl/sram_march_checker_pkg.sv
// Shared types for the SRAM March C- self-test engine.
// Element table, controller states and checkword offsets.
package sram_march_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    typedef enum logic [2:0] {
        PH_SETUP,
        PH_WR,
        PH_ISS,
        PH_WT,
        PH_CHK
    } phase_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic down;
        logic rd_bg;
        logic wr_bg;
    } elem_t;

    localparam logic [2:0]  ELEM_LAST = 3'd5;
    localparam logic [15:0] CHK_RUN   = 16'd0;
    localparam logic [15:0] CHK_PASS  = 16'd1;
    localparam logic [15:0] CHK_FAIL  = 16'd2;

    // Field order: rd, wr, down, rd_bg, wr_bg
    function automatic elem_t elem_cfg(input logic [2:0] e);
        case (e)
            3'd0:    elem_cfg = 5'b01000;
            3'd1:    elem_cfg = 5'b11001;
            3'd2:    elem_cfg = 5'b11010;
            3'd3:    elem_cfg = 5'b11101;
            3'd4:    elem_cfg = 5'b11110;
            default: elem_cfg = 5'b10000;
        endcase
    endfunction

endpackage

// File: rtl/sram_march_checker_addr_gen.sv
// Loadable up/down address counter for the march sequencer.
// Direction is latched on load; last flags the final address of the sweep.
module sram_march_checker_addr_gen
    import sram_march_checker_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dir_down,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic down_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            down_q <= dir_down;
            addr   <= dir_down ? '1 : '0;
        end else if (step) begin
            addr <= down_q ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign last = down_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_checker.sv
// March C- self-test controller for a single-port SRAM macro.
// Publishes progress and result as a pad checkword.
module sram_march_checker
    import sram_march_checker_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 32,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] SIG_BASE = 16'hAB60
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              abort,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic [15:0]       checkbits,
    output logic [15:0]       checkbits_oeb
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(READ_LAT - 1);

    state_t            state, state_nxt;
    phase_t            phase, phase_nxt;
    logic [2:0]        elem, elem_nxt;
    logic [LAT_W-1:0]  cnt, cnt_nxt;
    logic              gen_load, gen_down, gen_step;
    logic [ADDR_W-1:0] addr;
    logic              last;
    elem_t             cfg, cfg_next;
    logic [DATA_W-1:0] rd_exp, wr_data;
    logic              miss;

    assign cfg      = elem_cfg(elem);
    assign cfg_next = elem_cfg(elem + 3'd1);
    assign rd_exp   = {DATA_W{cfg.rd_bg}};
    assign wr_data  = {DATA_W{cfg.wr_bg}};
    assign miss     = (phase == PH_CHK) && (sram_dout != rd_exp);

    sram_march_checker_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (gen_load),
        .dir_down (gen_down),
        .step     (gen_step),
        .addr     (addr),
        .last     (last)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= ST_IDLE;
            phase         <= PH_SETUP;
            elem          <= '0;
            cnt           <= '0;
            checkbits     <= '0;
            checkbits_oeb <= '1;
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_data     <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            elem  <= elem_nxt;
            cnt   <= cnt_nxt;
            unique case (state_nxt)
                ST_RUN:  checkbits <= SIG_BASE + CHK_RUN;
                ST_PASS: checkbits <= SIG_BASE + CHK_PASS;
                ST_FAIL: checkbits <= SIG_BASE + CHK_FAIL;
                default: checkbits <= '0;
            endcase
            if (state_nxt == ST_RUN) checkbits_oeb <= '0;
            if (state != ST_RUN && state_nxt == ST_RUN) begin
                fail_addr <= '0;
                fail_elem <= '0;
                fail_data <= '0;
            end
            if (state == ST_RUN && state_nxt == ST_FAIL) begin
                fail_addr <= addr;
                fail_elem <= elem;
                fail_data <= sram_dout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        elem_nxt  = elem;
        cnt_nxt   = cnt;
        gen_load  = 1'b0;
        gen_down  = 1'b0;
        gen_step  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    unique case (phase)
                        PH_SETUP: phase_nxt = PH_WR;
                        PH_WR: begin
                            if (last) begin
                                elem_nxt  = elem + 3'd1;
                                gen_load  = 1'b1;
                                gen_down  = cfg_next.down;
                                phase_nxt = cfg_next.rd ? PH_ISS : PH_WR;
                            end else begin
                                gen_step = 1'b1;
                            end
                        end
                        PH_ISS: begin
                            phase_nxt = PH_WT;
                            cnt_nxt   = '0;
                        end
                        PH_WT: begin
                            if (cnt == LAT_MAX) phase_nxt = PH_CHK;
                            else cnt_nxt = cnt + LAT_W'(1);
                        end
                        PH_CHK: begin
                            if (miss) begin
                                state_nxt = ST_FAIL;
                            end else if (!last) begin
                                gen_step  = 1'b1;
                                phase_nxt = PH_ISS;
                            end else if (elem == ELEM_LAST) begin
                                state_nxt = ST_PASS;
                            end else begin
                                elem_nxt  = elem + 3'd1;
                                gen_load  = 1'b1;
                                gen_down  = cfg_next.down;
                                phase_nxt = cfg_next.rd ? PH_ISS : PH_WR;
                            end
                        end
                        default: phase_nxt = PH_SETUP;
                    endcase
                end
            end
            default: begin
                // Abort outranks start so a held abort keeps the engine parked.
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                    phase_nxt = PH_SETUP;
                    elem_nxt  = '0;
                    gen_load  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        busy      = (state == ST_RUN);
        done      = (state == ST_PASS) || (state == ST_FAIL);
        pass      = (state == ST_PASS);
        if (state == ST_RUN) begin
            sram_addr = addr;
            unique case (phase)
                PH_WR: begin
                    sram_csb = 1'b0;
                    sram_web = 1'b0;
                    sram_din = wr_data;
                end
                PH_ISS: sram_csb = 1'b0;
                PH_CHK: begin
                    if (cfg.wr && !miss) begin
                        sram_csb = 1'b0;
                        sram_web = 1'b0;
                        sram_din = wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_march_checker.sv
// Directed bench for the March C- checker: golden op scoreboard,
// injected stuck-at and coupling faults, abort/reset and a READ_LAT=3 run.
module tb_sram_march_checker;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    typedef struct packed {
        logic          web;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst, start, abort, start3;
    logic abort3;

    logic          csb, web, busy, done, pass;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] din, dout, fail_data;
    logic [2:0]    fail_elem;
    logic [15:0]   checkbits, oeb;

    logic          csb3, web3, busy3, done3, pass3;
    logic [AW-1:0] addr3, fail_addr3;
    logic [DW-1:0] din3, dout3, fail_data3;
    logic [2:0]    fail_elem3;
    logic [15:0]   checkbits3, oeb3;

    logic [DW-1:0] mem  [N];
    logic [DW-1:0] mem3 [N];
    logic [DW-1:0] p0, p1;
    logic          v0, v1;

    op_t sbq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  fault = 0;
    int  wr9 = 0;
    int  since = 0;
    int  cyc;

    always #5 clk = ~clk;

    sram_march_checker #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .SIG_BASE(16'hAB60)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
        .sram_csb(csb), .sram_web(web), .sram_addr(addr),
        .sram_din(din), .sram_dout(dout),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
        .checkbits(checkbits), .checkbits_oeb(oeb)
    );

    sram_march_checker #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .SIG_BASE(16'hAB60)
    ) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start3), .abort(abort3),
        .sram_csb(csb3), .sram_web(web3), .sram_addr(addr3),
        .sram_din(din3), .sram_dout(dout3),
        .busy(busy3), .done(done3), .pass(pass3),
        .fail_addr(fail_addr3), .fail_elem(fail_elem3),
        .fail_data(fail_data3),
        .checkbits(checkbits3), .checkbits_oeb(oeb3)
    );

    // SRAM with optional faults, read latency 1
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                mem[addr] <= din;
                if (fault == 2 && addr == 4'd3 && din[0]) mem[4][0] <= 1'b1;
            end else begin
                dout <= mem[addr] |
                        ((fault == 1 && addr == 4'd9) ? 32'h20 : 32'h0);
            end
        end
    end

    // Fault-free SRAM, read latency 3
    always @(posedge clk) begin
        v0 <= !csb3 && web3;
        p0 <= mem3[addr3];
        v1 <= v0;
        p1 <= p0;
        if (v1) dout3 <= p1;
        if (!csb3 && !web3) mem3[addr3] <= din3;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        op_t e;
        if (!csb) begin
            if (!web && addr == 4'd9) wr9++;
            if (sbq.size() == 0) begin
                chk("op_extra", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("op", {web, addr, web ? 32'h0 : din}, e);
            end
        end
        if (since >= 1 && since <= 3) chk("csb3_wait", csb3, 1);
        if (!csb3 && web3) since = 1;
        else if (since > 0 && since < 4) since++;
    end

    task automatic push_golden();
        sbq.delete();
        for (int a = 0; a < N; a++) sbq.push_back({1'b0, 4'(a), 32'h0});
        for (int el = 1; el <= 5; el++) begin
            for (int i = 0; i < N; i++) begin
                int   a;
                logic wbg;
                a   = (el == 3 || el == 4) ? N - 1 - i : i;
                wbg = (el == 1 || el == 3);
                sbq.push_back({1'b1, 4'(a), 32'h0});
                if (el != 5) sbq.push_back({1'b0, 4'(a), {DW{wbg}}});
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 600) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", csb, 1);
        chk("rst_web", web, 1);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_faddr", fail_addr, 0);
        chk("rst_felem", fail_elem, 0);
        chk("rst_fdata", fail_data, 0);
        chk("rst_chk", checkbits, 16'h0000);
        chk("rst_oeb", oeb, 16'hFFFF);
        chk("rst_csb3", csb3, 1);
        @(negedge clk) rst = 1'b0;

        fault = 0;
        push_golden();
        pulse_start();
        chk("run_chk", checkbits, 16'hAB60);
        chk("run_busy", busy, 1);
        chk("run_oeb", oeb, 16'h0000);
        chk("setup_csb", csb, 1);
        wait_done(cyc);
        chk("pass_cycles", cyc, 257);
        chk("pass_pass", pass, 1);
        chk("pass_chk", checkbits, 16'hAB61);
        chk("pass_busy", busy, 0);
        chk("pass_ops_left", sbq.size(), 0);

        fault = 1;
        wr9 = 0;
        push_golden();
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_pass", pass, 0);
        wait_done(cyc);
        chk("sa_cycles", cyc, 47);
        chk("sa_pass", pass, 0);
        chk("sa_faddr", fail_addr, 9);
        chk("sa_felem", fail_elem, 1);
        chk("sa_fdata", fail_data, 32'h20);
        chk("sa_chk", checkbits, 16'hAB62);
        chk("sa_wr9", wr9, 1);
        chk("sa_ops_left", sbq.size(), 125);

        fault = 2;
        push_golden();
        pulse_start();
        chk("clr_faddr", fail_addr, 0);
        chk("clr_felem", fail_elem, 0);
        chk("clr_fdata", fail_data, 0);
        chk("clr_done", done, 0);
        wait_done(cyc);
        chk("cf_cycles", cyc, 32);
        chk("cf_faddr", fail_addr, 4);
        chk("cf_felem", fail_elem, 1);
        chk("cf_fdata", fail_data, 32'h1);
        chk("cf_chk", checkbits, 16'hAB62);
        chk("cf_ops_left", sbq.size(), 135);

        fault = 0;
        push_golden();
        pulse_start();
        repeat (118) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("ab_chk", checkbits, 16'h0000);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_csb", csb, 1);
        chk("ab_oeb", oeb, 16'h0000);
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        chk("sa_idle_busy", busy, 0);
        chk("sa_idle_chk", checkbits, 16'h0000);
        push_golden();
        pulse_start();
        wait_done(cyc);
        chk("re_cycles", cyc, 257);
        chk("re_pass", pass, 1);
        chk("re_ops_left", sbq.size(), 0);

        push_golden();
        pulse_start();
        repeat (29) @(posedge clk);
        pulse_start();
        chk("ign_busy", busy, 1);
        chk("ign_chk", checkbits, 16'hAB60);
        repeat (38) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_csb", csb, 1);
        chk("mr_web", web, 1);
        chk("mr_addr", addr, 0);
        chk("mr_din", din, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_chk", checkbits, 16'h0000);
        chk("mr_oeb", oeb, 16'hFFFF);
        @(negedge clk) rst = 1'b0;

        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        chk("l3_run_chk", checkbits3, 16'hAB60);
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("l3_cycles", cyc, 417);
        chk("l3_pass", pass3, 1);
        chk("l3_chk", checkbits3, 16'hAB61);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
